// File: rtl/wii_blob_decoder.sv
// wii_blob_decoder: decodes one blob's x/y/size from an IR camera extended-mode report, with a stale-frame timeout.
// Define BLOB_AVG_EN to average each new sample with the previous committed one.
module wii_blob_decoder #(
  parameter int BLOB_SEL       = 0,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_start,
  input  logic [7:0] data,
  input  logic       data_valid,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic [3:0] size,
  output logic       xy_valid,
  output logic       stale
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [3:0] B0 = 4'(1 + 3 * BLOB_SEL);
  typedef enum logic [1:0] {IDLE, HDR, BODY, COMMIT} state_t;
  state_t state;
  logic [3:0] byte_idx;
  logic [9:0] sx, sy, nx, ny;
  logic [3:0] ss;
  logic [CW-1:0] cnt;
`ifdef BLOB_AVG_EN
  // A no-blob on either side makes the average meaningless, so pass the new sample through
  logic raw;
  assign raw = (y == 10'h3FF) || (sy == 10'h3FF);
  assign nx  = raw ? sx : 10'(({1'b0, x} + {1'b0, sx} + 11'd1) >> 1);
  assign ny  = raw ? sy : 10'(({1'b0, y} + {1'b0, sy} + 11'd1) >> 1);
`else
  assign nx = sx;
  assign ny = sy;
`endif
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      byte_idx <= '0;
      sx       <= '0;
      sy       <= '0;
      ss       <= '0;
      cnt      <= '0;
      x        <= 10'h3FF;
      y        <= 10'h3FF;
      size     <= '0;
      xy_valid <= 1'b0;
      stale    <= 1'b1;
    end else begin
      xy_valid <= 1'b0;
      if (state == COMMIT) begin
        x        <= nx;
        y        <= ny;
        size     <= ss;
        xy_valid <= 1'b1;
        stale    <= 1'b0;
        cnt      <= '0;
      end else if (cnt != CW'(TIMEOUT_CYCLES)) begin
        cnt <= cnt + CW'(1);
        if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          stale <= 1'b1;
          x     <= 10'h3FF;
          y     <= 10'h3FF;
          size  <= '0;
        end
      end
      // A new frame_start always restarts parsing; in COMMIT the commit above still completes
      if (frame_start) begin
        state    <= data_valid ? BODY : HDR;
        byte_idx <= 4'd1;
      end else if (state == HDR) begin
        if (data_valid) begin
          state    <= BODY;
          byte_idx <= 4'd1;
        end
      end else if (state == BODY) begin
        if (data_valid) begin
          if (byte_idx == B0) sx[7:0] <= data;
          if (byte_idx == B0 + 4'd1) sy[7:0] <= data;
          if (byte_idx == B0 + 4'd2) {sy[9:8], sx[9:8], ss} <= data;
          if (byte_idx == 4'd12) state <= COMMIT;
          else byte_idx <= byte_idx + 4'd1;
        end
      end else if (state == COMMIT) begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_wii_blob_decoder.sv
// tb_wii_blob_decoder: scoreboard bench for wii_blob_decoder with BLOB_SEL=0, TIMEOUT_CYCLES=100.
module tb_wii_blob_decoder;
  localparam int TO = 100;
  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [3:0] s;
  } exp_t;
  logic clk = 0, reset = 0, frame_start = 0, data_valid = 0;
  logic [7:0] data = '0;
  logic [9:0] x, y;
  logic [3:0] size;
  logic xy_valid, stale;
  int vectors = 0, miscompares = 0, mcnt = 0;
  logic [9:0] mx = 10'h3FF, my = 10'h3FF;
  exp_t q[$];

  wii_blob_decoder #(.BLOB_SEL(0), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .data(data), .data_valid(data_valid),
    .x(x), .y(y), .size(size), .xy_valid(xy_valid), .stale(stale)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic exp_t model(input logic [9:0] fx, input logic [9:0] fy, input logic [3:0] fs);
    exp_t e;
    e.x = fx;
    e.y = fy;
    e.s = fs;
`ifdef BLOB_AVG_EN
    if (my != 10'h3FF && fy != 10'h3FF) begin
      e.x = 10'((11'(mx) + 11'(fx) + 11'd1) >> 1);
      e.y = 10'((11'(my) + 11'(fy) + 11'd1) >> 1);
    end
`endif
    return e;
  endfunction

  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    mcnt = !reset ? 0 : (mcnt < TO ? mcnt + 1 : TO);
    if (mcnt == TO) begin
      mx = 10'h3FF;
      my = 10'h3FF;
    end
    if (xy_valid) begin
      vectors++;
      if (q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_pulse got x=%0d y=%0d size=%0d", x, y, size);
      end else begin
        e = q.pop_front();
        if ({x, y, size, stale} !== {e.x, e.y, e.s, 1'b0}) begin
          miscompares++;
          $display("FAIL commit got x=%0d y=%0d size=%0d stale=%0d want x=%0d y=%0d size=%0d stale=0",
                   x, y, size, stale, e.x, e.y, e.s);
        end
      end
    end
  endtask

  task automatic send_frame(input int gap, input int nbytes, input logic [9:0] fx,
                            input logic [9:0] fy, input logic [3:0] fs);
    exp_t e;
    frame_start = 1;
    if (gap > 0) begin
      data_valid = 0;
      step();
    end
    for (int i = 0; i < nbytes; i++) begin
      if (i > 0)
        for (int g = 0; g < gap; g++) begin
          data_valid  = 0;
          frame_start = 0;
          step();
        end
      data = i == 1 ? fx[7:0] : i == 2 ? fy[7:0] : i == 3 ? {fy[9:8], fx[9:8], fs} : 8'($urandom);
      data_valid  = 1;
      frame_start = (i == 0 && gap == 0);
      if (i == 12) begin
        e = model(fx, fy, fs);
        q.push_back(e);
      end
      step();
    end
    data_valid  = 0;
    frame_start = 0;
    if (nbytes == 13) begin
      step();
      mcnt = 0;
      mx = e.x;
      my = e.y;
      vectors++;
      if (q.size() != 0) begin
        miscompares++;
        $display("FAIL missing_pulse got pending=%0d want 0", q.size());
        q.delete();
      end
    end
  endtask

  task automatic test_reset();
    reset = 0;
    repeat (3) step();
    reset = 1;
    #1;
    vectors++;
    if ({x, y, size, stale, xy_valid} !== {10'd1023, 10'd1023, 4'd0, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL reset got x=%0d y=%0d size=%0d stale=%0d v=%0d want 1023 1023 0 1 0",
               x, y, size, stale, xy_valid);
    end
    repeat (10) step();
  endtask

  task automatic test_basic();
    send_frame(0, 13, 10'd677, 10'd451, 4'd5);
  endtask

  task automatic test_gaps();
    send_frame(5, 13, 10'd677, 10'd451, 4'd5);
    send_frame(0, 13, 10'd1023, 10'd1023, 4'd15);
  endtask

  task automatic test_abort();
    send_frame(0, 8, 10'd500, 10'd600, 4'd3);
    send_frame(0, 13, 10'd10, 10'd20, 4'd7);
  endtask

  task automatic test_back_to_back();
    send_frame(0, 13, 10'd123, 10'd456, 4'd9);
    send_frame(0, 13, 10'd789, 10'd321, 4'd2);
    for (int i = 0; i < 5; i++) begin
      data = 8'($urandom);
      data_valid = 1;
      step();
    end
    data_valid = 0;
    vectors++;
    if ({x, y} !== {mx, my}) begin
      miscompares++;
      $display("FAIL trailing_bytes got x=%0d y=%0d want x=%0d y=%0d", x, y, mx, my);
    end
  endtask

  task automatic test_timeout();
    send_frame(0, 13, 10'd300, 10'd400, 4'd2);
    repeat (TO - 1) step();
    vectors++;
    if (stale !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_early got stale=%0d want 0", stale);
    end
    step();
    vectors++;
    if ({x, y, size, stale} !== {10'd1023, 10'd1023, 4'd0, 1'b1}) begin
      miscompares++;
      $display("FAIL timeout got x=%0d y=%0d size=%0d stale=%0d want 1023 1023 0 1", x, y, size, stale);
    end
    send_frame(0, 13, 10'd50, 10'd60, 4'd1);
  endtask

  task automatic test_avg();
    send_frame(0, 13, 10'd0, 10'd1023, 4'd0);
    send_frame(0, 13, 10'd100, 10'd200, 4'd4);
    send_frame(0, 13, 10'd103, 10'd210, 4'd6);
    vectors++;
`ifdef BLOB_AVG_EN
    if ({x, y} !== {10'd102, 10'd205}) begin
      miscompares++;
      $display("FAIL avg got x=%0d y=%0d want x=102 y=205", x, y);
    end
`else
    if ({x, y} !== {10'd103, 10'd210}) begin
      miscompares++;
      $display("FAIL raw got x=%0d y=%0d want x=103 y=210", x, y);
    end
`endif
  endtask

  task automatic test_reset_mid();
    send_frame(0, 6, 10'd1, 10'd2, 4'd3);
    reset = 0;
    #1;
    vectors++;
    if ({x, y, size, stale} !== {10'd1023, 10'd1023, 4'd0, 1'b1}) begin
      miscompares++;
      $display("FAIL reset_mid got x=%0d y=%0d size=%0d stale=%0d want 1023 1023 0 1", x, y, size, stale);
    end
    mx = 10'h3FF;
    my = 10'h3FF;
    step();
    reset = 1;
    send_frame(0, 13, 10'd222, 10'd333, 4'd8);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_abort();
    test_back_to_back();
    test_timeout();
    test_avg();
    test_reset_mid();
    repeat (3) step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
